arith_operand_sequencer: RTL and testbench

Sequential front end for the 3-bit adder/subtractor stage. It debounces five raw board keys, guides the user through entering operand A, operand B and the add/subtract mode, and drives these to the adder/subtractor. It then captures the adder's 4-bit result and presents it as a held, valid value. A confirm press in the result state chains the result back in as the next operand A, which turns the combinational stage into a step-by-step calculator.

---
 rtl/arith_seq_pkg.sv | 18 +
 rtl/button_debouncer.sv | 51 +++++
 rtl/arith_operand_sequencer.sv | 129 ++++++++++++
 tb/tb_arith_operand_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_seq_pkg.sv
// Shared types for the operand sequencer: FSM states and key indices.
package arith_seq_pkg;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      CALC    = 2'd2,
      SHOW    = 2'd3
   } state_t;

   localparam int BTN_INC  = 0;
   localparam int BTN_DEC  = 1;
   localparam int BTN_CFM  = 2;
   localparam int BTN_MODE = 3;
   localparam int BTN_CLR  = 4;
   localparam int NUM_BTN  = 5;

endpackage

// File: rtl/button_debouncer.sv
// One key: 2-flop synchronizer, stable-count debouncer, registered
// rising-edge press pulse.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic pressed
);

   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_deb;
   logic          r_deb_q;
   logic          r_pulse;
   logic [CW-1:0] r_cnt;
   logic          w_differ;

   assign w_differ = r_sync2 ^ r_deb;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_deb_q <= 1'b0;
         r_pulse <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
         r_deb_q <= r_deb;
         r_pulse <= r_deb & ~r_deb_q;
         if (!w_differ) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign pressed = r_pulse;

endmodule

// File: rtl/arith_operand_sequencer.sv
// Key-driven operand entry and result capture for the add/sub stage;
// confirming in SHOW chains the result back in as operand A.
module arith_operand_sequencer
   import arith_seq_pkg::*;
#(
   parameter int W               = 3,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn,
   input  logic [W:0]         res,
   output logic [W-1:0]       a,
   output logic [W-1:0]       b,
   output logic               mode,
   output logic [1:0]         state,
   output logic [W:0]         result,
   output logic               result_valid
);

   logic [NUM_BTN-1:0] w_press;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_key
      button_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clock  (clock),
         .reset  (reset),
         .raw    (btn[gi]),
         .pressed(w_press[gi])
      );
   end

   logic w_clr;
   logic w_cfm;
   logic w_mode;
   logic w_inc;
   logic w_dec;

   // Only the highest-priority pulse survives; the rest are dropped.
   always_comb begin
      w_clr  = 1'b0;
      w_cfm  = 1'b0;
      w_mode = 1'b0;
      w_inc  = 1'b0;
      w_dec  = 1'b0;
      if (w_press[BTN_CLR])       w_clr  = 1'b1;
      else if (w_press[BTN_CFM])  w_cfm  = 1'b1;
      else if (w_press[BTN_MODE]) w_mode = 1'b1;
      else if (w_press[BTN_INC])  w_inc  = 1'b1;
      else if (w_press[BTN_DEC])  w_dec  = 1'b1;
   end

   state_t       r_state;
   state_t       w_state_nx;
   logic [W-1:0] r_a;
   logic [W-1:0] w_a_nx;
   logic [W-1:0] r_b;
   logic [W-1:0] w_b_nx;
   logic         r_mode;
   logic         w_mode_nx;
   logic [W:0]   r_result;
   logic [W:0]   w_result_nx;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state  <= ENTER_A;
         r_a      <= '0;
         r_b      <= '0;
         r_mode   <= 1'b0;
         r_result <= '0;
      end else begin
         r_state  <= w_state_nx;
         r_a      <= w_a_nx;
         r_b      <= w_b_nx;
         r_mode   <= w_mode_nx;
         r_result <= w_result_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_a_nx      = r_a;
      w_b_nx      = r_b;
      w_mode_nx   = r_mode;
      w_result_nx = r_result;
      if (w_clr && r_state != CALC) begin
         w_state_nx  = ENTER_A;
         w_a_nx      = '0;
         w_b_nx      = '0;
         w_mode_nx   = 1'b0;
         w_result_nx = '0;
      end else begin
         case (r_state)
            ENTER_A: begin
               if (w_cfm)       w_state_nx = ENTER_B;
               else if (w_mode) w_mode_nx  = ~r_mode;
               else if (w_inc)  w_a_nx     = r_a + 1'b1;
               else if (w_dec)  w_a_nx     = r_a - 1'b1;
            end
            ENTER_B: begin
               if (w_cfm)       w_state_nx = CALC;
               else if (w_mode) w_mode_nx  = ~r_mode;
               else if (w_inc)  w_b_nx     = r_b + 1'b1;
               else if (w_dec)  w_b_nx     = r_b - 1'b1;
            end
            CALC: begin
               w_result_nx = res;
               w_state_nx  = SHOW;
            end
            SHOW: begin
               if (w_cfm) begin
                  w_a_nx     = r_result[W-1:0];
                  w_state_nx = ENTER_A;
               end
            end
            default: w_state_nx = ENTER_A;
         endcase
      end
   end

   assign a            = r_a;
   assign b            = r_b;
   assign mode         = r_mode;
   assign state        = r_state;
   assign result       = r_result;
   assign result_valid = (r_state == SHOW);

endmodule

// File: tb/tb_arith_operand_sequencer.sv
// Scoreboard bench: key presses feed a behavioural calculator model whose
// expected output changes (with their cycle) are checked by a monitor.
module tb_arith_operand_sequencer;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic       mode;
      logic [1:0] st;
      logic [3:0] res;
      logic       rv;
   } obs_t;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] btn   = 5'd0;
   logic [3:0] res;
   logic [2:0] a;
   logic [2:0] b;
   logic       mode;
   logic [1:0] state;
   logic [3:0] result;
   logic       result_valid;

   int cyc = 0;
   int vec = 0;
   int err = 0;

   int   q_cyc[$];
   obs_t q_val[$];

   int   m_a = 0;
   int   m_b = 0;
   int   m_mode = 0;
   int   m_st = 0;
   int   m_res = 0;
   obs_t m_last = 'x;

   localparam logic [4:0] K_INC = 5'b00001;
   localparam logic [4:0] K_DEC = 5'b00010;
   localparam logic [4:0] K_CFM = 5'b00100;
   localparam logic [4:0] K_MOD = 5'b01000;
   localparam logic [4:0] K_CLR = 5'b10000;

   arith_operand_sequencer #(
      .W(3),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .btn         (btn),
      .res         (res),
      .a           (a),
      .b           (b),
      .mode        (mode),
      .state       (state),
      .result      (result),
      .result_valid(result_valid)
   );

   // Behavioural adder/subtractor: bit 3 is carry (add) or not-borrow (sub).
   assign res = mode ? ({1'b0, a} + 4'd8 - {1'b0, b})
                     : ({1'b0, a} + {1'b0, b});

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic obs_t model_obs();
      obs_t o;
      o.a    = 3'(m_a);
      o.b    = 3'(m_b);
      o.mode = 1'(m_mode);
      o.st   = 2'(m_st);
      o.res  = 4'(m_res);
      o.rv   = (m_st == 3);
      return o;
   endfunction

   task automatic post(input int c);
      obs_t o;
      o = model_obs();
      if (o !== m_last) begin
         q_cyc.push_back(c);
         q_val.push_back(o);
         m_last = o;
      end
   endtask

   task automatic model_reset(input int c);
      m_a = 0; m_b = 0; m_mode = 0; m_res = 0; m_st = 0;
      post(c);
   endtask

   task automatic model_keys(input logic [4:0] k, input int c);
      if (m_st == 2) return;
      if (k[4]) begin
         model_reset(c);
         return;
      end
      if (k[2]) begin
         if (m_st == 0) m_st = 1;
         else if (m_st == 1) begin
            m_st = 2;
            post(c);
            m_res = m_mode ? (m_a + 8 - m_b) % 16 : (m_a + m_b);
            m_st = 3;
            post(c + 1);
            return;
         end else begin
            m_a = m_res % 8;
            m_st = 0;
         end
      end else if (k[3]) begin
         if (m_st < 2) m_mode = 1 - m_mode;
      end else if (k[0]) begin
         if (m_st == 0) m_a = (m_a + 1) % 8;
         if (m_st == 1) m_b = (m_b + 1) % 8;
      end else if (k[1]) begin
         if (m_st == 0) m_a = (m_a + 7) % 8;
         if (m_st == 1) m_b = (m_b + 7) % 8;
      end
      post(c);
   endtask

   // Raw edge driven after cycle t is first sampled at t+1 and acts at t+8.
   task automatic press(input logic [4:0] k, input int hold);
      int t;
      @(negedge clock);
      t = cyc;
      btn = k;
      if (hold >= 4) model_keys(k, t + 8);
      repeat (hold) @(negedge clock);
      btn = 5'd0;
      repeat (14) @(negedge clock);
   endtask

   task automatic reset_pulse(input logic [4:0] held, input int extra);
      int t;
      @(negedge clock);
      t = cyc;
      reset = 1'b0;
      btn = held;
      model_reset(t + 1);
      @(negedge clock);
      reset = 1'b1;
      t = cyc;
      if (held != 5'd0 && extra >= 4) model_keys(held, t + 8);
      repeat (extra) @(negedge clock);
      btn = 5'd0;
      repeat (14) @(negedge clock);
   endtask

   always @(negedge clock) begin : mon
      obs_t o;
      obs_t prev;
      obs_t ev;
      int   ec;
      o = {a, b, mode, state, result, result_valid};
      if (o !== prev) begin
         vec++;
         if (q_val.size() == 0) begin
            err++;
            $display("FAIL unexpected_change got=%h at cycle %0d", o, cyc);
         end else begin
            ec = q_cyc.pop_front();
            ev = q_val.pop_front();
            if (o !== ev || cyc != ec) begin
               err++;
               $display("FAIL output_step got=%h@%0d want=%h@%0d",
                        o, cyc, ev, ec);
            end
         end
         prev = o;
      end else if (q_cyc.size() > 0 && cyc > q_cyc[0]) begin
         vec++;
         err++;
         ec = q_cyc.pop_front();
         ev = q_val.pop_front();
         $display("FAIL missing_change got=%h want=%h@%0d", o, ev, ec);
      end
   end

   initial begin
      int r;
      int h;
      logic [4:0] k;
      post(1);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (4) @(negedge clock);

      repeat (8) press(K_INC, 4);
      press(K_CFM, 3);
      press(K_CFM, 4);
      press(K_CLR, 4);

      repeat (5) press(K_INC, 4);
      press(K_CFM, 5);
      repeat (6) press(K_INC, 4);
      press(K_CFM, 4);

      press(K_CLR, 6);
      repeat (2) press(K_INC, 4);
      press(K_MOD, 4);
      press(K_CFM, 4);
      repeat (3) press(K_DEC, 4);
      press(K_CFM, 4);
      press(K_CFM, 4);

      press(K_INC | K_CLR, 4);

      press(K_INC, 4);
      press(K_CFM, 4);
      press(K_INC, 4);
      press(K_CFM, 4);
      reset_pulse(K_INC, 6);
      press(K_MOD, 4);
      @(negedge clock);
      btn = K_DEC;
      repeat (2) @(negedge clock);
      reset_pulse(5'd0, 0);

      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         h = $urandom_range(4, 6);
         k = 5'(1 << $urandom_range(0, 4));
         if (r >= 6 && r < 8) k = 5'($urandom_range(1, 31));
         if (r >= 8) h = $urandom_range(1, 3);
         press(k, h);
      end

      repeat (20) @(negedge clock);
      vec++;
      if (q_val.size() != 0) begin
         err++;
         $display("FAIL drain got=%0d pending want=0", q_val.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
